// File: rtl/change_dispenser_pkg.sv
// Shared vending definitions: change width, dispenser FSM states and coin values.
package vending_pkg;

    // Width of the nickel-change count carried with each vend pulse.
    localparam int CHANGE_W = 3;

    // Coin values in nickel units, shared with the vending FSM.
    localparam int NICKEL_VAL  = 1;
    localparam int DIME_VAL    = 2;
    localparam int QUARTER_VAL = 5;

    // Dispenser FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEND = 2'd1,
        REQ  = 2'd2,
        GAP  = 2'd3
    } disp_state_t;

    // Width of a queue occupancy count that can hold 0..depth inclusive.
    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the vend-event input, the hopper handshake and the dispenser status.
interface change_dispenser_if
    import vending_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) ();

    localparam int CNT_W = fifo_count_w(FIFO_DEPTH);

    logic                i_soda;
    logic [CHANGE_W-1:0] i_change;
    logic                i_nickle_ack;
    logic                o_soda_motor;
    logic                o_nickle_req;
    logic                o_busy;
    logic [CNT_W-1:0]    o_fifo_count;
    logic                o_overflow;

    // Vending FSM / hopper side: produces vend events and acks, observes status.
    modport master (
        output i_soda,
        output i_change,
        output i_nickle_ack,
        input  o_soda_motor,
        input  o_nickle_req,
        input  o_busy,
        input  o_fifo_count,
        input  o_overflow
    );

    // Dispenser side.
    modport slave (
        input  i_soda,
        input  i_change,
        input  i_nickle_ack,
        output o_soda_motor,
        output o_nickle_req,
        output o_busy,
        output o_fifo_count,
        output o_overflow
    );

endinterface

// File: rtl/change_dispenser_fifo.sv
// Synchronous FIFO of pending vend events (nickel-change counts).
// A push while full is dropped unless a pop happens the same cycle.
module vend_fifo
    import vending_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              push,
    input  logic                              pop,
    input  logic [CHANGE_W-1:0]               din,
    output logic [CHANGE_W-1:0]               dout,
    output logic [fifo_count_w(FIFO_DEPTH)-1:0] count,
    output logic                              full,
    output logic                              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = fifo_count_w(FIFO_DEPTH);

    logic [CHANGE_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                wr_en;
    logic                rd_en;

    assign full  = (count == CW'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: queues vend events, runs the soda motor for a fixed time,
// then pays the owed change one nickel at a time over a req/ack handshake.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int MOTOR_CYCLES = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    change_dispenser_if.slave        bus
);

    localparam int CNT_W = fifo_count_w(FIFO_DEPTH);
    localparam int MW    = (MOTOR_CYCLES > 1) ? $clog2(MOTOR_CYCLES) : 1;
    localparam logic [MW-1:0] MOTOR_LAST = MW'(MOTOR_CYCLES - 1);

    disp_state_t         state;
    disp_state_t         state_n;
    logic [CHANGE_W-1:0] remaining;
    logic [CHANGE_W-1:0] remaining_n;
    logic [MW-1:0]       motor_cnt;
    logic [MW-1:0]       motor_cnt_n;
    logic                pop;
    logic [CHANGE_W-1:0] head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                overflow;

    vend_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (bus.i_soda),
        .pop   (pop),
        .din   (bus.i_change),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic: pop in IDLE, time the motor in VEND, pay nickels via REQ/GAP.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        motor_cnt_n = motor_cnt;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    remaining_n = head;
                    motor_cnt_n = '0;
                    state_n     = VEND;
                end
            end
            VEND: begin
                if (motor_cnt == MOTOR_LAST) begin
                    state_n = (remaining != '0) ? REQ : IDLE;
                end else begin
                    motor_cnt_n = motor_cnt + MW'(1);
                end
            end
            REQ: begin
                if (bus.i_nickle_ack) begin
                    remaining_n = remaining - CHANGE_W'(1);
                    state_n     = GAP;
                end
            end
            GAP: begin
                state_n = (remaining != '0) ? REQ : IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // FSM, owed-change and motor-timer registers; reset abandons any event in progress.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            remaining <= '0;
            motor_cnt <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            motor_cnt <= motor_cnt_n;
        end
    end

    // Sticky record of any vend event lost to a full queue.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow <= 1'b0;
        end else if (bus.i_soda && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Outputs decode registered state only.
    assign bus.o_soda_motor = (state == VEND);
    assign bus.o_nickle_req = (state == REQ);
    assign bus.o_busy       = (state != IDLE) || !fifo_empty;
    assign bus.o_fifo_count = fifo_count;
    assign bus.o_overflow   = overflow;

endmodule
